ts_null_inserter: RTL and testbench
===================================

TS_NULL_INSERTER -- requirements
Module: ts_null_inserter

Interface
REQ-001 Parameter NULL_FILL, default 8'hFF: payload byte value used in inserted null packets.
REQ-002 CLK  input  1  byte clock, same clock as the T2-MI packer output (TS_DCLK_IN domain).
REQ-003 RST  input  1  asynchronous, active-low reset; all state clears while RST=0.
REQ-004 DATA_IN  input  8  T2-MI-over-TS byte from the packer.
REQ-005 ENA_IN  input  1  DATA_IN valid strobe.
REQ-006 PSYNC_IN  input  1  high with ENA_IN on byte 0 (0x47) of each 188-byte packet.
REQ-007 TICK  input  1  output byte-rate strobe; one output byte per TICK.
REQ-008 DATA_OUT  output  8  constant-rate TS byte.
REQ-009 ENA_OUT  output  1  DATA_OUT valid.
REQ-010 PSYNC_OUT  output  1  high with ENA_OUT on byte 0 of each output packet.
REQ-011 NULL_CNT  output  16  count of null packets started; wraps at 0xFFFF to 0.
REQ-012 OVERFLOW  output  1  sticky flag, set when an input packet is dropped.
REQ-013 RUNT  output  1  sticky flag, set when an input packet is truncated.

Function
REQ-014 Buffering: two 188-byte packet slots (ping-pong), each with a registered FULL flag; write slot pointer and read slot pointer each 1 bit.
REQ-015 Input FSM states: IDLE, WRITE, DROP.
REQ-016 IDLE: ENA_IN&PSYNC_IN with the write slot not FULL -> store byte at index 0, go to WRITE; with the write slot FULL -> set OVERFLOW, go to DROP.
REQ-017 IDLE: ENA_IN without PSYNC_IN -> byte ignored, stay in IDLE.
REQ-018 WRITE: each ENA_IN byte is stored at index 1..187; on index 187 set FULL of the write slot, toggle the write pointer, go to IDLE.
REQ-019 WRITE: ENA_IN&PSYNC_IN before index 187 -> set RUNT, discard the partial slot (FULL stays 0), restart the same slot at index 0 with this byte.
REQ-020 DROP: ignore bytes until the next ENA_IN&PSYNC_IN, then apply the REQ-016 rule to that byte.
REQ-021 Output byte counter 0..187 advances only on TICK; wraps 187->0.
REQ-022 On TICK at counter 0 the source is chosen for the whole packet: the read slot if its FULL=1 (registered value), else null.
REQ-023 Null packet bytes: 0x47, 0x1F, 0xFF, 0x10, then 184 x NULL_FILL; NULL_CNT increments at byte 0 of each null packet.
REQ-024 Slot source: bytes 0..187 are read from the read slot; on byte 187 clear that FULL flag and toggle the read pointer.
REQ-025 Latency: DATA_OUT/ENA_OUT/PSYNC_OUT are registered and appear exactly 1 cycle after the TICK that produced them; ENA_OUT=0 on all other cycles.
REQ-026 Same-cycle FULL set (REQ-018) and counter-0 decision (REQ-022): the decision uses the old FULL value (null sent), and the slot is picked up at the next packet boundary.
REQ-027 Same-cycle FULL clear (REQ-024) and FULL set on the other slot: both take effect independently.
REQ-028 TICK without data is legal; output never stalls: a packet, once started, always completes 188 bytes.

Reset
REQ-029 RST=0 forces DATA_OUT=0, ENA_OUT=0, PSYNC_OUT=0, NULL_CNT=0, OVERFLOW=0, RUNT=0, both FULL=0, both pointers=0, output counter=0, input FSM=IDLE.
REQ-030 RST asserted mid-packet aborts both input and output packets immediately; after release the first output packet starts at byte 0.
REQ-031 Slot RAM contents are not reset.

Verification
REQ-032 TICK every cycle, no input -> continuous null packets: 0x47 0x1F 0xFF 0x10 + 184x0xFF; PSYNC_OUT every 188 cycles; NULL_CNT=1 after first byte.
REQ-033 One input packet (0x47, bytes 1..187 = index) written before counter 0 -> next output packet equals it byte-for-byte, 1 cycle after each TICK, followed by null packets.
REQ-034 Three back-to-back input packets with no TICK -> packets 1 and 2 buffered, packet 3 dropped, OVERFLOW=1; enabling TICK then outputs packet 1, then packet 2, then nulls.
REQ-035 PSYNC_IN at input index 100 -> RUNT=1, partial data never output, following complete packet output intact.
REQ-036 Slot FULL set on the same cycle as a counter-0 TICK -> null packet sent first, stored packet sent in the next packet period.
REQ-037 RST pulsed low at output byte 50 -> all outputs 0 during reset; first TICK after release gives PSYNC_OUT=1, DATA_OUT=0x47.

Source files
------------

// File: rtl/ts_null_inserter_if.sv
// Byte stream bundle for the TS null inserter: packer-side input,
// constant-rate output and status.
interface ts_null_inserter_if;
    logic [7:0]  data_in;
    logic        ena_in;
    logic        psync_in;
    logic        tick;
    logic [7:0]  data_out;
    logic        ena_out;
    logic        psync_out;
    logic [15:0] null_cnt;
    logic        overflow;
    logic        runt;

    modport master (
        output data_in, ena_in, psync_in, tick,
        input  data_out, ena_out, psync_out, null_cnt, overflow, runt
    );

    modport slave (
        input  data_in, ena_in, psync_in, tick,
        output data_out, ena_out, psync_out, null_cnt, overflow, runt
    );
endinterface

// File: rtl/ts_null_inserter.sv
// Ping-pong buffers whole 188-byte TS packets from the packer and replays them
// at the TICK rate, filling idle packet periods with null packets.
module ts_null_inserter #(
    parameter logic [7:0] NULL_FILL = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    ts_null_inserter_if.slave  bus
);
    localparam int         PKT_LEN = 188;
    localparam logic [7:0] LAST    = 8'd187;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} in_state_t;

    in_state_t   state, state_nx;
    logic [7:0]  wr_idx, wr_idx_nx, wr_addr;
    logic        wr_en, set_full, ovf_set, runt_set;
    logic        wr_ptr, rd_ptr;
    logic [1:0]  full;
    logic [7:0]  mem [2][PKT_LEN];

    logic [7:0]  out_cnt;
    logic        src_slot, use_slot, clr_full;
    logic [7:0]  data_q;
    logic        ena_q, psync_q, overflow_q, runt_q;
    logic [15:0] null_cnt_q;

    logic sop;
    assign sop = bus.ena_in & bus.psync_in;

    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        case (idx)
            8'd0:    return 8'h47;
            8'd1:    return 8'h1F;
            8'd2:    return 8'hFF;
            8'd3:    return 8'h10;
            default: return NULL_FILL;
        endcase
    endfunction

    always_comb begin
        state_nx  = state;
        wr_idx_nx = wr_idx;
        wr_addr   = wr_idx;
        wr_en     = 1'b0;
        set_full  = 1'b0;
        ovf_set   = 1'b0;
        runt_set  = 1'b0;
        case (state)
            IDLE, DROP: begin
                if (sop) begin
                    if (!full[wr_ptr]) begin
                        wr_en     = 1'b1;
                        wr_addr   = 8'd0;
                        wr_idx_nx = 8'd1;
                        state_nx  = WRITE;
                    end else begin
                        ovf_set  = 1'b1;
                        state_nx = DROP;
                    end
                end
            end
            WRITE: begin
                // A new sync mid-packet abandons the partial slot and reuses it
                if (sop) begin
                    runt_set  = 1'b1;
                    wr_en     = 1'b1;
                    wr_addr   = 8'd0;
                    wr_idx_nx = 8'd1;
                end else if (bus.ena_in) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST) begin
                        set_full  = 1'b1;
                        wr_idx_nx = 8'd0;
                        state_nx  = IDLE;
                    end else begin
                        wr_idx_nx = wr_idx + 8'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Source is latched at byte 0 from the registered FULL, so a slot filled
    // on that same edge waits for the next packet boundary.
    assign use_slot = (out_cnt == 8'd0) ? full[rd_ptr] : src_slot;
    assign clr_full = bus.tick & use_slot & (out_cnt == LAST);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr][wr_addr] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_idx     <= 8'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            full       <= 2'b00;
            out_cnt    <= 8'd0;
            src_slot   <= 1'b0;
            data_q     <= 8'd0;
            ena_q      <= 1'b0;
            psync_q    <= 1'b0;
            null_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
            runt_q     <= 1'b0;
        end else begin
            state  <= state_nx;
            wr_idx <= wr_idx_nx;
            if (ovf_set)  overflow_q <= 1'b1;
            if (runt_set) runt_q     <= 1'b1;
            if (set_full) wr_ptr     <= ~wr_ptr;
            if (clr_full) begin
                full[rd_ptr] <= 1'b0;
                rd_ptr       <= ~rd_ptr;
            end
            if (set_full) full[wr_ptr] <= 1'b1;

            ena_q   <= bus.tick;
            psync_q <= bus.tick & (out_cnt == 8'd0);
            if (bus.tick) begin
                data_q  <= use_slot ? mem[rd_ptr][out_cnt] : null_byte(out_cnt);
                out_cnt <= (out_cnt == LAST) ? 8'd0 : out_cnt + 8'd1;
                if (out_cnt == 8'd0) begin
                    src_slot <= full[rd_ptr];
                    if (!full[rd_ptr]) null_cnt_q <= null_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.ena_out   = ena_q;
    assign bus.psync_out = psync_q;
    assign bus.null_cnt  = null_cnt_q;
    assign bus.overflow  = overflow_q;
    assign bus.runt      = runt_q;
endmodule

// File: tb/tb_ts_null_inserter.sv
// Scoreboard bench: expected output bytes are queued as stimulus is planned
// and drained by a monitor on every ENA_OUT.
module tb_ts_null_inserter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_nulls = 0;

    typedef struct { logic [7:0] d; logic ps; } exp_t;
    exp_t q[$];

    ts_null_inserter_if bus();

    ts_null_inserter #(.NULL_FILL(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pkt_byte(input int id, input int i);
        if (i == 0) return 8'h47;
        return 8'((i + id * 37) & 255);
    endfunction

    function automatic logic [7:0] null_ref(input int i);
        if (i == 0) return 8'h47;
        if (i == 1) return 8'h1F;
        if (i == 2) return 8'hFF;
        if (i == 3) return 8'h10;
        return 8'hFF;
    endfunction

    task automatic push_pkt(input int id);
        exp_t e;
        for (int i = 0; i < 188; i++) begin
            e.d = pkt_byte(id, i); e.ps = (i == 0); q.push_back(e);
        end
    endtask

    task automatic push_null(input int nbytes);
        exp_t e;
        for (int i = 0; i < nbytes; i++) begin
            e.d = null_ref(i); e.ps = (i == 0); q.push_back(e);
        end
        exp_nulls++;
    endtask

    task automatic send_bytes(input int id, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            bus.ena_in = 1'b1; bus.psync_in = (i == 0); bus.data_in = pkt_byte(id, i);
            step();
        end
        bus.ena_in = 1'b0; bus.psync_in = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        bus.tick = 1'b1;
        repeat (n) step();
        bus.tick = 1'b0;
    endtask

    task automatic check_nulls(input string tag);
        n_cmp++;
        if (bus.null_cnt !== 16'(exp_nulls)) begin
            n_err++;
            $display("FAIL %s null_cnt got %0d want %0d", tag, bus.null_cnt, exp_nulls);
        end
    endtask

    // Every output cycle must match the tick one cycle earlier and the queue head.
    task automatic monitor();
        logic t;
        exp_t e;
        forever begin
            @(posedge clk);
            t = rst_n ? bus.tick : 1'b0;
            @(negedge clk);
            if (rst_n) begin
                n_cmp++;
                if (bus.ena_out !== t) begin
                    n_err++;
                    $display("FAIL ena_out got %b want %b at %0t", bus.ena_out, t, $time);
                end
                if (bus.ena_out === 1'b1) begin
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_byte got %h with empty queue at %0t", bus.data_out, $time);
                    end else begin
                        e = q.pop_front();
                        if (bus.data_out !== e.d || bus.psync_out !== e.ps) begin
                            n_err++;
                            $display("FAIL out_byte got %h/%b want %h/%b at %0t",
                                     bus.data_out, bus.psync_out, e.d, e.ps, $time);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if ({bus.data_out, bus.ena_out, bus.psync_out, bus.null_cnt, bus.overflow, bus.runt} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_state got %h/%b/%b/%h/%b/%b want all zero",
                     bus.data_out, bus.ena_out, bus.psync_out, bus.null_cnt, bus.overflow, bus.runt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_null_stream();
        push_null(188);
        run_ticks(1);
        @(negedge clk);
        check_nulls("null_first_byte");
        #1;
        run_ticks(187);
        push_null(188);
        run_ticks(188);
        step();
        check_nulls("null_stream");
    endtask

    task automatic test_single_packet();
        send_bytes(0, 188);
        push_pkt(0);
        push_null(188);
        run_ticks(376);
        step();
        check_nulls("single_packet");
    endtask

    task automatic test_overflow();
        send_bytes(1, 188);
        send_bytes(2, 188);
        send_bytes(3, 188);
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow got %b want 1", bus.overflow);
        end
        push_pkt(1);
        push_pkt(2);
        push_null(188);
        run_ticks(564);
        step();
        check_nulls("overflow_drain");
    endtask

    task automatic test_runt();
        n_cmp++;
        if (bus.runt !== 1'b0) begin
            n_err++;
            $display("FAIL runt_before got %b want 0", bus.runt);
        end
        send_bytes(4, 100);
        send_bytes(5, 188);
        n_cmp++;
        if (bus.runt !== 1'b1) begin
            n_err++;
            $display("FAIL runt got %b want 1", bus.runt);
        end
        push_pkt(5);
        run_ticks(188);
        step();
        check_nulls("runt_packet");
    endtask

    task automatic test_same_cycle();
        push_null(188);
        push_pkt(6);
        for (int c = 0; c < 187 + 376; c++) begin
            bus.ena_in    = (c < 188);
            bus.psync_in  = (c == 0);
            bus.data_in   = pkt_byte(6, c);
            bus.tick      = (c >= 187);
            step();
        end
        bus.ena_in = 1'b0; bus.psync_in = 1'b0; bus.tick = 1'b0;
        step();
        check_nulls("same_cycle");
    endtask

    task automatic test_reset_mid();
        push_null(50);
        run_ticks(50);
        step();
        rst_n = 1'b0;
        bus.tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({bus.data_out, bus.ena_out, bus.psync_out, bus.null_cnt, bus.overflow, bus.runt} !== 28'd0) begin
                n_err++;
                $display("FAIL reset_mid got %h/%b/%b/%h/%b/%b want all zero",
                         bus.data_out, bus.ena_out, bus.psync_out, bus.null_cnt, bus.overflow, bus.runt);
            end
        end
        bus.tick = 1'b0;
        q.delete();
        exp_nulls = 0;
        rst_n = 1'b1;
        push_null(188);
        run_ticks(188);
        step();
        check_nulls("after_reset");
    endtask

    initial begin
        bus.data_in = 8'd0; bus.ena_in = 1'b0; bus.psync_in = 1'b0; bus.tick = 1'b0;
        fork monitor(); join_none
        test_reset();
        test_null_stream();
        test_single_packet();
        test_overflow();
        test_runt();
        test_same_cycle();
        test_reset_mid();
        repeat (3) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drained got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
